fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between fetch_unit and its environment: pipeline control,
// predictor update, instruction memory port and the IF/DE register outputs.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_inc4;
  logic            out_pred_taken;
  logic [XLEN-1:0] out_pred_target;

  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  imem_rdata,
    output imem_en, imem_addr,
    output out_valid, out_instr, out_pc, out_pc_inc4, out_pred_taken, out_pred_target
  );

  modport slave (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output imem_rdata,
    input  imem_en, imem_addr,
    input  out_valid, out_instr, out_pc, out_pc_inc4, out_pred_taken, out_pred_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Two-stage instruction fetch: F1 issues pc_q and predicts the next PC from a
// direct-mapped BHT; F2 pairs the returning word with its PC into the IF/DE register.
module fetch_unit #(
  parameter int              XLEN        = 32,
  parameter int              BHT_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}}
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int              IDX     = $clog2(BHT_ENTRIES);
  localparam int              TAGW    = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
  endfunction

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_f2_pc;
  logic            r_f2_valid;
  logic            r_f2_pred_taken;
  logic [XLEN-1:0] r_f2_pred_target;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_instr;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_pc_inc4;
  logic            r_out_pred_taken;
  logic [XLEN-1:0] r_out_pred_target;

  logic [1:0]      r_bht_cnt [BHT_ENTRIES];
  logic            r_bht_vld [BHT_ENTRIES];
  logic [TAGW-1:0] r_bht_tag [BHT_ENTRIES];
  logic [XLEN-1:0] r_bht_tgt [BHT_ENTRIES];

  logic [IDX-1:0]  w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic [IDX-1:0]  w_up_idx;
  logic [TAGW-1:0] w_up_tag;
  logic [XLEN-1:0] w_pc_inc4;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;
  logic            w_unused_upd_bits;

  assign w_lk_idx          = r_pc[IDX+1:2];
  assign w_lk_tag          = r_pc[XLEN-1:IDX+2];
  assign w_up_idx          = bus.upd_pc[IDX+1:2];
  assign w_up_tag          = bus.upd_pc[XLEN-1:IDX+2];
  assign w_unused_upd_bits = ^bus.upd_pc[1:0];
  assign w_pc_inc4         = r_pc + PC_STEP;

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign w_pred_taken  = r_bht_vld[w_lk_idx] && (r_bht_tag[w_lk_idx] == w_lk_tag) &&
                         r_bht_cnt[w_lk_idx][1];
  assign w_pred_target = w_pred_taken ? r_bht_tgt[w_lk_idx] : w_pc_inc4;

  // While stalled, re-read the F2 address so its word is on imem_rdata at release.
  assign bus.imem_en   = ~rst;
  assign bus.imem_addr = (bus.stall && !bus.redirect_valid) ? r_f2_pc : r_pc;

  assign bus.out_valid       = r_out_valid;
  assign bus.out_instr       = r_out_instr;
  assign bus.out_pc          = r_out_pc;
  assign bus.out_pc_inc4     = r_out_pc_inc4;
  assign bus.out_pred_taken  = r_out_pred_taken;
  assign bus.out_pred_target = r_out_pred_target;

  // F1/F2/IF-DE pipeline advance; redirect overrides stall, reset overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc              <= RESET_PC;
      r_f2_pc           <= ZERO;
      r_f2_valid        <= 1'b0;
      r_f2_pred_taken   <= 1'b0;
      r_f2_pred_target  <= ZERO;
      r_out_valid       <= 1'b0;
      r_out_instr       <= ZERO;
      r_out_pc          <= ZERO;
      r_out_pc_inc4     <= ZERO;
      r_out_pred_taken  <= 1'b0;
      r_out_pred_target <= ZERO;
    end else if (bus.redirect_valid) begin
      r_pc        <= bus.redirect_pc;
      r_f2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc              <= w_pred_target;
      r_f2_pc           <= r_pc;
      r_f2_valid        <= 1'b1;
      r_f2_pred_taken   <= w_pred_taken;
      r_f2_pred_target  <= w_pred_target;
      r_out_valid       <= r_f2_valid;
      r_out_instr       <= bus.imem_rdata;
      r_out_pc          <= r_f2_pc;
      r_out_pc_inc4     <= r_f2_pc + PC_STEP;
      r_out_pred_taken  <= r_f2_pred_taken;
      r_out_pred_target <= r_f2_pred_target;
    end else begin
      r_f2_valid  <= r_f2_valid;
      r_out_valid <= r_out_valid;
    end
  end

  // Counter and valid state; only these need a known value after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht_cnt[i] <= 2'b01;
        r_bht_vld[i] <= 1'b0;
      end
    end else if (bus.upd_valid) begin
      r_bht_cnt[w_up_idx] <= sat_cnt(r_bht_cnt[w_up_idx], bus.upd_taken);
      if (bus.upd_taken) begin
        r_bht_vld[w_up_idx] <= 1'b1;
      end else begin
        r_bht_vld[w_up_idx] <= r_bht_vld[w_up_idx];
      end
    end else begin
      r_bht_cnt[w_up_idx] <= r_bht_cnt[w_up_idx];
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.upd_valid && bus.upd_taken) begin
      r_bht_tag[w_up_idx] <= w_up_tag;
      r_bht_tgt[w_up_idx] <= bus.upd_target;
    end else begin
      r_bht_tag[w_up_idx] <= r_bht_tag[w_up_idx];
      r_bht_tgt[w_up_idx] <= r_bht_tgt[w_up_idx];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-bit instance runs the main sequence against a
// scoreboard of expected IF/DE outputs; a 16-bit instance checks PC wrap-around.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus32 ();
  fetch_unit_if #(.XLEN(16)) bus16 ();

  fetch_unit #(.XLEN(32), .BHT_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus32));
  fetch_unit #(.XLEN(16), .BHT_ENTRIES(16), .RESET_PC(16'hFFFC)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16));

  // Memory whose word equals its address, one cycle read latency.
  always @(posedge clk) begin
    bus32.imem_rdata <= bus32.imem_addr;
    bus16.imem_rdata <= bus16.imem_addr;
  end

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic pt,
                      input logic [31:0] ptgt);
    exp_t e;
    sb.push_back('{v: v, pc: pc, pt: pt, ptgt: ptgt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_valid", 32'(bus32.out_valid), 32'(e.v));
    if (e.v) begin
      chk("out_pc", bus32.out_pc, e.pc);
      chk("out_instr", bus32.out_instr, e.pc);
      chk("out_pc_inc4", bus32.out_pc_inc4, e.pc + 32'd4);
      chk("out_pred_taken", 32'(bus32.out_pred_taken), 32'(e.pt));
      chk("out_pred_target", bus32.out_pred_target, e.ptgt);
    end
  endtask

  task automatic step_np(input logic v, input logic [31:0] pc);
    step(v, pc, 1'b0, pc + 32'd4);
  endtask

  task automatic redir(input logic [31:0] a);
    bus32.redirect_valid = 1'b1;
    bus32.redirect_pc    = a;
    step_np(1'b0, 32'h0);
    bus32.redirect_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus32.upd_valid  = 1'b1;
    bus32.upd_pc     = pc;
    bus32.upd_taken  = taken;
    bus32.upd_target = tgt;
  endtask

  initial begin
    rst = 1'b1;
    bus32.stall = 1'b0; bus32.redirect_valid = 1'b0; bus32.redirect_pc = 32'h0;
    bus32.upd_valid = 1'b0; bus32.upd_pc = 32'h0; bus32.upd_taken = 1'b0; bus32.upd_target = 32'h0;
    bus16.stall = 1'b0; bus16.redirect_valid = 1'b0; bus16.redirect_pc = 16'h0;
    bus16.upd_valid = 1'b0; bus16.upd_pc = 16'h0; bus16.upd_taken = 1'b0; bus16.upd_target = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus32.out_valid), 32'd0);
    chk("rst_out_pc", bus32.out_pc, 32'd0);
    chk("rst_out_instr", bus32.out_instr, 32'd0);
    chk("rst_out_pred_target", bus32.out_pred_target, 32'd0);
    chk("rst_imem_en", 32'(bus32.imem_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("imem_en", 32'(bus32.imem_en), 32'd1);
    chk("first_addr", bus32.imem_addr, 32'd0);

    step_np(1'b0, 32'h0);
    chk("w16_valid0", 32'(bus16.out_valid), 32'd0);
    step_np(1'b1, 32'h0);
    chk("w16_pc0", 32'(bus16.out_pc), 32'h0000_FFFC);
    chk("w16_inc4_0", 32'(bus16.out_pc_inc4), 32'h0000_0000);
    chk("w16_instr0", 32'(bus16.out_instr), 32'h0000_FFFC);
    step_np(1'b1, 32'h4);
    chk("w16_pc1", 32'(bus16.out_pc), 32'h0000_0000);
    chk("w16_inc4_1", 32'(bus16.out_pc_inc4), 32'h0000_0004);
    step_np(1'b1, 32'h8);

    // Stall three cycles with out_pc = 8
    bus32.stall = 1'b1;
    #1;
    chk("stall_addr", bus32.imem_addr, 32'hC);
    repeat (3) step_np(1'b1, 32'h8);
    bus32.stall = 1'b0;
    step_np(1'b1, 32'hC);
    step_np(1'b1, 32'h10);

    // Redirect together with stall
    bus32.stall = 1'b1;
    redir(32'h100);
    bus32.stall = 1'b0;
    step_np(1'b0, 32'h0);
    step_np(1'b1, 32'h100);
    step_np(1'b1, 32'h104);

    // Two taken updates at 0x20 -> 0x80
    upd(32'h20, 1'b1, 32'h80);
    step_np(1'b1, 32'h108);
    step_np(1'b1, 32'h10C);
    bus32.upd_valid = 1'b0;
    redir(32'h20);
    step_np(1'b0, 32'h0);
    step(1'b1, 32'h20, 1'b1, 32'h80);
    step_np(1'b1, 32'h80);

    // Alias at the same index, different tag
    redir(32'h60);
    step_np(1'b0, 32'h0);
    step_np(1'b1, 32'h60);
    step_np(1'b1, 32'h64);

    // Not-taken update: counter 3->2, target untouched
    upd(32'h20, 1'b0, 32'h999);
    step_np(1'b1, 32'h68);
    bus32.upd_valid = 1'b0;
    redir(32'h20);
    step_np(1'b0, 32'h0);
    step(1'b1, 32'h20, 1'b1, 32'h80);
    step_np(1'b1, 32'h80);
    upd(32'h20, 1'b0, 32'h999);
    step_np(1'b1, 32'h84);
    bus32.upd_valid = 1'b0;
    redir(32'h20);
    step_np(1'b0, 32'h0);
    step_np(1'b1, 32'h20);
    step_np(1'b1, 32'h24);

    // Update in the same cycle as the lookup of that PC
    redir(32'h200);
    upd(32'h200, 1'b1, 32'h300);
    step_np(1'b0, 32'h0);
    bus32.upd_valid = 1'b0;
    step_np(1'b1, 32'h200);
    step_np(1'b1, 32'h204);
    redir(32'h200);
    step_np(1'b0, 32'h0);
    step(1'b1, 32'h200, 1'b1, 32'h300);
    step_np(1'b1, 32'h300);

    // Reset during stall and redirect discards everything, including the BHT
    rst = 1'b1;
    bus32.stall = 1'b1;
    bus32.redirect_valid = 1'b1;
    bus32.redirect_pc = 32'h400;
    step_np(1'b0, 32'h0);
    chk("rst_mid_pc", bus32.out_pc, 32'd0);
    rst = 1'b0;
    bus32.stall = 1'b0;
    bus32.redirect_valid = 1'b0;
    step_np(1'b0, 32'h0);
    step_np(1'b1, 32'h0);
    step_np(1'b1, 32'h4);
    redir(32'h20);
    step_np(1'b0, 32'h0);
    step_np(1'b1, 32'h20);
    step_np(1'b1, 32'h24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
